// File: rtl/cdc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_pkg
//  Description : Shared types and constants for the req/ack clock-domain-
//                crossing handshake. The source-side transmitter and the
//                destination-side receiver both use the state encoding
//                below.
//  Revision    : 1.0 - initial release
// ============================================================================
package cdc_pkg;

  // Fewest synchronizer flops that give acceptable metastability settling
  // on the returned acknowledge.
  localparam int MIN_SYNC_STAGES = 2;

  // Handshake phase of the transmitter:
  //   IDLE    - no word outstanding, may accept a new one
  //   REQ     - req asserted, waiting for the ack to rise
  //   RELEASE - req dropped, waiting for the ack to fall
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } cdc_tx_state_e;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/cdc_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_sync
//  Description : Multi-flop synchronizer bringing a signal into the clk_i
//                domain. Each bit is synchronized independently, so a
//                multi-bit input must be gray-coded or otherwise
//                single-bit-change by construction.
//  Ports       : clk_i - destination clock
//                d_i   - asynchronous input
//                q_o   - synchronized output, SYNC_STAGES cycles of latency
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Deliberately not reset. Resetting the chain would make the synchronized
  // value read 0 for a few cycles even though the far side may still be
  // driving 1, and the handshake logic relies on seeing the true level.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    sync_q[0] <= d_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule : cdc_sync
`default_nettype wire

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_handshake_tx
//  Description : Source-side end of a 4-phase req/ack clock-domain-crossing
//                handshake. A word is taken over a valid/ready interface,
//                held on data_o while req_o is raised, and released once the
//                destination has acknowledged and withdrawn its acknowledge.
//  Ports       : clk_i     - source-domain clock
//                rst_i     - synchronous active-high reset
//                valid_i   - upstream word valid
//                data_i    - upstream word
//                ready_o   - a word can be accepted this cycle
//                req_o     - request to destination domain (registered)
//                data_o    - word presented to destination (registered)
//                ack_i     - acknowledge from destination (asynchronous)
//                done_o    - one-cycle pulse on transfer completion
//                timeout_o - sticky flag: ack edge not seen in time
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             done_o,
  output logic             timeout_o
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("cdc_handshake_tx: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  // --------------------------------------------------------------------------
  // Acknowledge synchronizer. Everything below looks only at ack_s, so there
  // is no combinational path from ack_i to any output.
  // --------------------------------------------------------------------------
  logic ack_s;

  cdc_sync #(
    .WIDTH       (1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i (clk_i),
    .d_i   (ack_i),
    .q_o   (ack_s)
  );

  // --------------------------------------------------------------------------
  // Handshake FSM
  // --------------------------------------------------------------------------
  cdc_tx_state_e    state_q, state_d;
  logic             req_q,   req_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             done_d;

  // A new word is only taken once the destination has fully withdrawn its
  // acknowledge. This also covers a stale ack left over from a transfer that
  // was cut short by reset, and a spurious ack seen while idle.
  assign ready_o = (state_q == IDLE) && !ack_s;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_i && ready_o) begin
          state_d = REQ;
          req_d   = 1'b1;
          data_d  = data_i;
        end
      end

      REQ: begin
        if (ack_s) begin
          state_d = RELEASE;
          req_d   = 1'b0;
        end
      end

      RELEASE: begin
        // The completion pulse is decoded in the last RELEASE cycle, so
        // ready_o is still low while done_o is high and the next word can
        // only be taken on the following cycle.
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
    end
  end

  assign req_o  = req_q;
  assign data_o = data_q;
  // Built only from registered state and the synchronized ack.
  assign done_o = done_d;

  // --------------------------------------------------------------------------
  // Optional handshake timeout
  // --------------------------------------------------------------------------
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             timeout_q, timeout_d;

    // Counts cycles spent waiting in one phase of the handshake. Any phase
    // change restarts it; reaching the limit raises a sticky flag but never
    // aborts the transfer, since the destination may simply be slow.
    always_comb begin
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (state_d != state_q) begin
        cnt_d = '0;
      end else if (state_q != IDLE) begin
        if (cnt_q != C_LIMIT) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == C_LIMIT) begin
          timeout_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q     <= '0;
        timeout_q <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        timeout_q <= timeout_d;
      end
    end

    assign timeout_o = timeout_q;
  end else begin : g_no_timeout
    assign timeout_o = 1'b0;
  end

endmodule : cdc_handshake_tx
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_handshake_tx
//  Description : Directed self-checking bench for cdc_handshake_tx. The
//                destination side is modelled by tasks that drive ack_i.
//                A second instance with the timeout disabled runs on the
//                same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic [7:0] data_i;
  logic       ack_i;

  logic       ready_o, req_o, done_o, timeout_o;
  logic [7:0] data_o;
  logic       ready0_o, req0_o, done0_o, timeout0_o;
  logic [7:0] data0_o;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .req_o     (req_o),
    .data_o    (data_o),
    .ack_i     (ack_i),
    .done_o    (done_o),
    .timeout_o (timeout_o)
  );

  cdc_handshake_tx #(
    .WIDTH          (8),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (0)
  ) dut0 (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .data_i    (data_i),
    .ready_o   (ready0_o),
    .req_o     (req0_o),
    .data_o    (data0_o),
    .ack_i     (ack_i),
    .done_o    (done0_o),
    .timeout_o (timeout0_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Words seen on data_o at every done_o pulse.
  logic [7:0] done_data[$];
  int         done_cnt0 = 0;

  always @(negedge clk) begin
    if (done_o)  done_data.push_back(data_o);
    if (done0_o) done_cnt0++;
  end

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word and wait (bounded) until it has been taken.
  task automatic accept(input logic [7:0] d);
    int n;
    data_i  = d;
    valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 20) begin
      step();
      n++;
    end
    step();
    check("accept_req", req_o, 1);
    check("accept_data", data_o, d);
  endtask

  // Destination model: ack after one cycle, drop ack once req falls,
  // then wait for the completion pulse.
  task automatic finish_xfer(input logic [7:0] exp);
    int n;
    step();
    ack_i = 1'b1;
    n = 0;
    while (req_o && n < 20) begin
      step();
      n++;
    end
    check("req_fall", req_o, 0);
    ack_i = 1'b0;
    n = 0;
    while (!done_o && n < 20) begin
      step();
      n++;
    end
    check("done_data", {done_o, data_o}, {1'b1, exp});
  endtask

  logic [7:0] exp_seq [10];
  logic       stable;

  initial begin
    int n;
    exp_seq = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h77, 8'h99, 8'hC3};
    rst_i   = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    ack_i   = 1'b0;
    repeat (3) step();

    // ---- reset state
    check("rst_req", req_o, 0);
    check("rst_data", data_o, 0);
    check("rst_done", done_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_req0", req0_o, 0);
    rst_i = 1'b0;
    step();

    // ---- single transfer with exact timing
    accept(8'hA5);
    check("t1_ready_busy", ready_o, 0);
    valid_i = 1'b0;
    step();
    step();
    check("t1_req_hold", req_o, 1);
    step();
    ack_i = 1'b1;
    step();
    check("t1_req_ack1", req_o, 1);
    step();
    check("t1_req_ack2", req_o, 1);
    step();
    check("t1_req_fall", req_o, 0);
    check("t1_no_done", done_o, 0);
    ack_i = 1'b0;
    step();
    check("t1_done_early", done_o, 0);
    step();
    check("t1_done", done_o, 1);
    check("t1_done_ready", ready_o, 0);
    check("t1_done_data", data_o, 8'hA5);
    step();
    check("t1_done_end", done_o, 0);
    check("t1_ready_again", ready_o, 1);

    // ---- data stability while upstream keeps driving a new word
    accept(8'h3C);
    data_i = 8'hFF;
    stable = 1'b1;
    step();
    ack_i = 1'b1;
    n = 0;
    while (req_o && n < 20) begin
      step();
      if (data_o !== 8'h3C) stable = 1'b0;
      n++;
    end
    check("stab_req_fall", req_o, 0);
    ack_i = 1'b0;
    while (!done_o && n < 40) begin
      step();
      if (data_o !== 8'h3C) stable = 1'b0;
      n++;
    end
    check("stab_done", done_o, 1);
    check("stab_data", data_o, 8'h3C);
    check("stab_ready_on_done", ready_o, 0);
    check("stab_held", stable, 1);
    step();
    check("stab_ready_after", ready_o, 1);
    check("stab_not_yet", req_o, 0);
    step();
    check("stab_ff_req", req_o, 1);
    check("stab_ff_data", data_o, 8'hFF);
    valid_i = 1'b0;
    finish_xfer(8'hFF);

    // ---- back-to-back words with valid held high
    for (int w = 1; w <= 4; w++) begin
      accept(8'(w));
      finish_xfer(8'(w));
    end
    valid_i = 1'b0;

    // ---- reset in the middle of REQ with ack asserted
    accept(8'h5A);
    valid_i = 1'b0;
    step();
    ack_i = 1'b1;
    step();
    rst_i = 1'b1;
    step();
    check("mid_rst_req", req_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_ready", ready_o, 0);
    rst_i   = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h77;
    step();
    check("mid_stale_ready", ready_o, 0);
    check("mid_stale_req", req_o, 0);
    ack_i = 1'b0;
    step();
    check("mid_sync_ready", ready_o, 0);
    step();
    check("mid_resume_ready", ready_o, 1);
    step();
    check("mid_accept_req", req_o, 1);
    check("mid_accept_data", data_o, 8'h77);
    valid_i = 1'b0;
    finish_xfer(8'h77);

    // ---- spurious ack while idle
    step();
    ack_i = 1'b1;
    step();
    step();
    check("spur_ready", ready_o, 0);
    valid_i = 1'b1;
    data_i  = 8'h99;
    step();
    step();
    check("spur_req", req_o, 0);
    check("spur_ready_hold", ready_o, 0);
    ack_i = 1'b0;
    step();
    check("spur_sync_ready", ready_o, 0);
    step();
    check("spur_resume", ready_o, 1);
    step();
    check("spur_accept_req", req_o, 1);
    check("spur_accept_data", data_o, 8'h99);
    valid_i = 1'b0;
    finish_xfer(8'h99);

    // ---- timeout: no ack for a long time
    accept(8'hC3);
    valid_i = 1'b0;
    repeat (9) step();
    check("to_before", timeout_o, 0);
    step();
    check("to_rise", timeout_o, 1);
    check("to_disabled", timeout0_o, 0);
    repeat (5) step();
    check("to_sticky", timeout_o, 1);
    check("to_still_req", req_o, 1);
    finish_xfer(8'hC3);
    step();
    check("to_after_done", timeout_o, 1);
    rst_i = 1'b1;
    step();
    check("to_cleared", timeout_o, 0);
    rst_i = 1'b0;
    step();

    // ---- completed-transfer record
    check("done_count", done_data.size(), 10);
    check("done_count0", done_cnt0, 10);
    for (int i = 0; i < 10 && i < done_data.size(); i++) begin
      check($sformatf("done_seq%0d", i), done_data[i], exp_seq[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_cdc_handshake_tx
`default_nettype wire
